// File: rtl/requantize_sequencer_mc.sv
// Requantization sequencer: walks channels, scalefactor bands and windows,
// fetching band widths and issuing one command per sample to the calculator.
module requantize_sequencer_mc #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 10,
  parameter int GRANULE_LEN = 576,
  parameter int CH_W        = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [1:0]               sfreq,
  input  logic [2*NUM_CH-1:0]      ch_mode,
  input  logic [ADDR_W*NUM_CH-1:0] ch_limit,
  output logic                     band_rd_en,
  output logic [1:0]               band_rd_mode,
  output logic [1:0]               band_rd_freq,
  output logic [4:0]               band_rd_cb,
  input  logic [7:0]               band_rd_width,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [CH_W-1:0]          cmd_ch,
  output logic [ADDR_W-1:0]        cmd_index,
  output logic [4:0]               cmd_cb,
  output logic [1:0]               cmd_window,
  output logic                     cmd_short,
  output logic                     cmd_zero,
  output logic                     cmd_last,
  input  logic                     calc_idle,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [3:0] {
    S_IDLE, S_CH_INIT, S_BAND_REQ, S_BAND_WAIT, S_EMIT,
    S_BAND_NEXT, S_CH_NEXT, S_DRAIN, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [4:0]          cb_q, cb_d;
  logic [1:0]          win_q, win_d;
  logic                sh_q, sh_d;
  logic [1:0]          mode_q, mode_d;
  logic [1:0]          freq_q, freq_d;
  logic [ADDR_W-1:0]   lim_q, lim_d;
  logic [7:0]          wid_q, wid_d;
  logic [7:0]          cnt_q, cnt_d;

  logic                idx_end, cnt_end, win_end;
  logic                mixed, final_band, last_ch;
  logic [4:0]          cb_last;
  logic [1:0]          mode_sel;
  logic [ADDR_W-1:0]   lim_sel;

  assign mode_sel = ch_mode[int'(ch_q)*2 +: 2];
  assign lim_sel  = ch_limit[int'(ch_q)*ADDR_W +: ADDR_W];
  assign idx_end  = idx_q == ADDR_W'(GRANULE_LEN-1);
  assign cnt_end  = cnt_q == wid_q - 8'd1;
  assign win_end  = !sh_q || win_q == 2'd2;
  assign mixed    = mode_q == 2'd1;
  assign last_ch  = int'(ch_q) == NUM_CH-1;

  // Mixed blocks run long cb 0..7, then restart the short region at cb 3.
  assign cb_last    = sh_q ? 5'd12 : (mixed ? 5'd7 : 5'd21);
  assign final_band = (cb_q == cb_last) && (sh_q || !mixed);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      idx_q   <= '0;
      cb_q    <= '0;
      win_q   <= '0;
      sh_q    <= 1'b0;
      mode_q  <= '0;
      freq_q  <= '0;
      lim_q   <= '0;
      wid_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      idx_q   <= idx_d;
      cb_q    <= cb_d;
      win_q   <= win_d;
      sh_q    <= sh_d;
      mode_q  <= mode_d;
      freq_q  <= freq_d;
      lim_q   <= lim_d;
      wid_q   <= wid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    idx_d   = idx_q;
    cb_d    = cb_q;
    win_d   = win_q;
    sh_d    = sh_q;
    mode_d  = mode_q;
    freq_d  = freq_q;
    lim_d   = lim_q;
    wid_d   = wid_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CH_INIT;
          ch_d    = '0;
        end
      end
      S_CH_INIT: begin
        mode_d  = mode_sel;
        freq_d  = sfreq;
        lim_d   = lim_sel;
        idx_d   = '0;
        cb_d    = '0;
        win_d   = '0;
        sh_d    = mode_sel == 2'd0;
        state_d = S_BAND_REQ;
      end
      S_BAND_REQ: state_d = S_BAND_WAIT;
      S_BAND_WAIT: begin
        wid_d   = band_rd_width;
        cnt_d   = '0;
        win_d   = '0;
        state_d = (band_rd_width == 8'd0) ? S_BAND_NEXT : S_EMIT;
      end
      S_EMIT: begin
        if (cmd_ready) begin
          idx_d = idx_q + 1'b1;
          if (idx_end) begin
            state_d = S_CH_NEXT;
          end else if (cnt_end) begin
            cnt_d = '0;
            if (win_end) state_d = S_BAND_NEXT;
            else         win_d   = win_q + 2'd1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_BAND_NEXT: begin
        if (cb_q != cb_last) begin
          cb_d    = cb_q + 5'd1;
          state_d = S_BAND_REQ;
        end else if (mixed && !sh_q) begin
          sh_d    = 1'b1;
          cb_d    = 5'd3;
          state_d = S_BAND_REQ;
        end else begin
          state_d = S_CH_NEXT;
        end
      end
      S_CH_NEXT: begin
        if (last_ch) begin
          state_d = S_DRAIN;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = S_CH_INIT;
        end
      end
      S_DRAIN: if (calc_idle) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A transfer in the abort cycle still advances the index above.
    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_comb begin
    busy         = state_q != S_IDLE;
    done         = state_q == S_DONE;
    band_rd_en   = state_q == S_BAND_REQ;
    cmd_valid    = state_q == S_EMIT;
    band_rd_mode = mode_q;
    band_rd_freq = freq_q;
    band_rd_cb   = cb_q;
    cmd_ch       = ch_q;
    cmd_index    = idx_q;
    cmd_cb       = cb_q;
    cmd_window   = win_q;
    cmd_short    = sh_q;
    cmd_zero     = cmd_valid && (idx_q >= lim_q);
    cmd_last     = cmd_valid && last_ch &&
                   (idx_end || (final_band && win_end && cnt_end));
  end

endmodule
